// File: rtl/fetch_unit.sv
// Instruction-fetch / memory-arbitration controller: owns PC, IR and the single memory port.
// Optional perf counters (fetch_count, stall_count) under `FETCH_UNIT_PERFCNT_EN.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              ls_req,
  input  logic [1:0]        ls_cmd,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  input  logic              ex_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
`ifdef FETCH_UNIT_PERFCNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count,
`endif
  output logic              halted
);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_ISSUE, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;
  logic              r_ir_valid;
  logic              r_halted;

  logic              w_ls_valid;
  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_ls_valid = ls_req && (ls_cmd == CMD_READ || ls_cmd == CMD_WRITE);

  // Address/wdata hold their last driven value whenever the port is idle.
  always_comb begin
    w_cmd   = CMD_NONE;
    w_addr  = r_addr_hold;
    w_wdata = r_wdata_hold;
    case (r_state)
      S_FETCH: begin
        w_cmd  = CMD_READ;
        w_addr = r_pc;
      end
      S_EXEC: begin
        if (ls_req) begin
          w_addr  = ls_addr;
          w_wdata = ls_wdata;
          if (w_ls_valid) w_cmd = ls_cmd;
        end
      end
      default: ;
    endcase
  end

  assign mem_cmd   = w_cmd;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  assign ls_ack    = (r_state == S_EXEC) && w_ls_valid && mem_ready;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign halted    = r_halted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_RST;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_ir_valid   <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_addr_hold  <= w_addr;
      r_wdata_hold <= w_wdata;
      r_ir_valid   <= 1'b0;
      case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            r_ir       <= read_data;
            r_pc       <= r_pc + ADDR_W'(1);
            r_ir_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_EXEC;
        S_EXEC: begin
          // ex_done during an outstanding ls_req is a protocol violation and is dropped.
          if (ex_done && !ls_req) begin
            if (halt_req) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              if (branch_taken) r_pc <= branch_target;
              r_state <= S_FETCH;
            end
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
    end
  end

`ifdef FETCH_UNIT_PERFCNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (r_state == S_FETCH) begin
      if (mem_ready) begin
        if (r_fetch_count != '1) r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        if (r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; fetched instructions are scoreboarded by queue.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] read_data;
  logic        mem_ready;
  logic [15:0] ir;
  logic        ir_valid;
  logic [8:0]  pc;
  logic        ls_req;
  logic [1:0]  ls_cmd;
  logic [8:0]  ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic        ex_done;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic        halt_req;
  logic        halted;
`ifdef FETCH_UNIT_PERFCNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_unit #(.ADDR_W(9), .DATA_W(16), .RESET_PC(9'd0)) dut (
    .clk(clk), .reset(reset),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .read_data(read_data), .mem_ready(mem_ready),
    .ir(ir), .ir_valid(ir_valid), .pc(pc),
    .ls_req(ls_req), .ls_cmd(ls_cmd), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ex_done(ex_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req),
`ifdef FETCH_UNIT_PERFCNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .halted(halted)
  );

  typedef struct {
    logic [15:0] ir;
    logic [8:0]  pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem [0:511];
  int          n_total = 0;
  int          n_pass  = 0;
  int          k;

  assign read_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [8:0] addr);
    exp_t e;
    e.ir = mem[addr];
    e.pc = addr + 9'd1;
    q.push_back(e);
  endtask

  // Bounded wait for ir_valid, then pop the scoreboard and compare.
  task automatic wait_iv(input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    while (ir_valid !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    chk("ir_valid_seen", {31'd0, ir_valid}, 32'd1);
    chk("sb_nonempty", {31'd0, q.size() > 0}, 32'd1);
    if (ir_valid === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_ir", {16'd0, ir}, {16'd0, e.ir});
      chk("sb_pc", {23'd0, pc}, {23'd0, e.pc});
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
    mem[0] = 16'hD105;
    reset = 1'b0; mem_ready = 1'b0; ls_req = 1'b0; ls_cmd = 2'b00;
    ls_addr = '0; ls_wdata = '0; ex_done = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt_req = 1'b0;
    #2;
    chk("rst_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_pc", {23'd0, pc}, 32'd0);
    chk("rst_flags", {29'd0, ir_valid, ls_ack, halted}, 32'd0);

    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    chk("f0_cmd", {30'd0, mem_cmd}, 32'd1);
    chk("f0_addr", {23'd0, mem_addr}, 32'd0);
    expect_fetch(9'd0);
    wait_iv(8, k);
    chk("f0_lat", k, 32'd1);
    chk("f0_ir", {16'd0, ir}, 32'hD105);
    chk("issue_cmd", {30'd0, mem_cmd}, 32'd0);
    step();
    chk("iv_pulse", {31'd0, ir_valid}, 32'd0);
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    chk("f1_cmd", {30'd0, mem_cmd}, 32'd1);
    chk("f1_addr", {23'd0, mem_addr}, 32'd1);
    chk("ir_hold", {16'd0, ir}, 32'hD105);
    expect_fetch(9'd1);
    wait_iv(8, k);
    step();

    // Branch to 5, then three wait cycles
    ex_done = 1'b1; branch_taken = 1'b1; branch_target = 9'd5;
    step();
    ex_done = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      chk("stall_cmd", {30'd0, mem_cmd}, 32'd1);
      chk("stall_addr", {23'd0, mem_addr}, 32'd5);
      if (i < 3) step();
    end
    expect_fetch(9'd5);
    wait_iv(8, k);
    chk("stall_lat", k, 32'd1);
`ifdef FETCH_UNIT_PERFCNT_EN
    chk("stall_count", stall_count, 32'd3);
    chk("fetch_count", fetch_count, 32'd3);
`endif
    step();

    // Store with one wait cycle; ex_done asserted alongside ls_req
    ls_req = 1'b1; ls_cmd = 2'b10; ls_addr = 9'h1F0; ls_wdata = 16'hBEEF;
    mem_ready = 1'b0; ex_done = 1'b1;
    #1;
    chk("st_cmd", {30'd0, mem_cmd}, 32'd2);
    chk("st_addr", {23'd0, mem_addr}, 32'h1F0);
    chk("st_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    chk("st_ack1", {31'd0, ls_ack}, 32'd0);
    step();
    mem_ready = 1'b1;
    #1;
    chk("st_ack2", {31'd0, ls_ack}, 32'd1);
    chk("st_cmd2", {30'd0, mem_cmd}, 32'd2);
    step();
    ls_req = 1'b0; ex_done = 1'b0;
    #1;
    chk("idle_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("idle_ack", {31'd0, ls_ack}, 32'd0);
    chk("idle_addr", {23'd0, mem_addr}, 32'h1F0);
    step();
    chk("exdone_ignored", {30'd0, mem_cmd}, 32'd0);
    chk("exdone_ignored_iv", {31'd0, ir_valid}, 32'd0);

    ls_req = 1'b1; ls_cmd = 2'b11;
    #1;
    chk("bad11_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("bad11_ack", {31'd0, ls_ack}, 32'd0);
    ls_cmd = 2'b00;
    #1;
    chk("bad00_ack", {31'd0, ls_ack}, 32'd0);
    ls_cmd = 2'b01; ls_addr = 9'h022;
    #1;
    chk("ld_cmd", {30'd0, mem_cmd}, 32'd1);
    chk("ld_addr", {23'd0, mem_addr}, 32'h022);
    chk("ld_ack", {31'd0, ls_ack}, 32'd1);
    step();
    ls_req = 1'b0;

    ex_done = 1'b1; branch_taken = 1'b1; branch_target = 9'h040;
    step();
    ex_done = 1'b0; branch_taken = 1'b0;
    chk("br_cmd", {30'd0, mem_cmd}, 32'd1);
    chk("br_addr", {23'd0, mem_addr}, 32'h040);
    expect_fetch(9'h040);
    wait_iv(8, k);
    step();

    ex_done = 1'b1; branch_taken = 1'b1; branch_target = 9'h1FF;
    step();
    ex_done = 1'b0; branch_taken = 1'b0;
    chk("wrap_addr", {23'd0, mem_addr}, 32'h1FF);
    expect_fetch(9'h1FF);
    wait_iv(8, k);
    chk("wrap_pc", {23'd0, pc}, 32'd0);
    step();

    ex_done = 1'b1; halt_req = 1'b1; branch_taken = 1'b1; branch_target = 9'h123;
    step();
    ex_done = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_cmd", {30'd0, mem_cmd}, 32'd0);
      chk("halt_pc", {23'd0, pc}, 32'd0);
      mem_ready = i[0];
      step();
    end

    reset = 1'b0;
    #1;
    chk("unhalt", {31'd0, halted}, 32'd0);
    reset = 1'b1; mem_ready = 1'b1;
    step();
    chk("rf0_addr", {23'd0, mem_addr}, 32'd0);
    expect_fetch(9'd0);
    wait_iv(8, k);
    step();
    ex_done = 1'b1;
    step();
    ex_done = 1'b0; mem_ready = 1'b0;
    chk("rf1_addr", {23'd0, mem_addr}, 32'd1);
    step();
    chk("rf1_wait_cmd", {30'd0, mem_cmd}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("abort_pc", {23'd0, pc}, 32'd0);
    chk("abort_ir", {16'd0, ir}, 32'd0);
    mem_ready = 1'b1;
    step();
    chk("inrst_cmd", {30'd0, mem_cmd}, 32'd0);
    chk("inrst_iv", {31'd0, ir_valid}, 32'd0);
    reset = 1'b1;
    step();
    chk("restart_cmd", {30'd0, mem_cmd}, 32'd1);
    chk("restart_addr", {23'd0, mem_addr}, 32'd0);
    chk("restart_ir", {16'd0, ir}, 32'd0);
    expect_fetch(9'd0);
    wait_iv(8, k);
    chk("restart_lat", k, 32'd1);
    chk("sb_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
